// File: rtl/serial_pattern_gen.sv
// serial_pattern_gen
//   Serial bit-pattern transmitter. A PAT_W-bit pattern is captured when Start
//   is seen while Ready is high, then shifted out MSB-first on Dout, one bit per
//   clock. The frame is repeated Repeat times (0 counts as 1) with GAP idle
//   cycles between consecutive frames.
//
// Parameters
//   PAT_W    pattern width in bits (>= 2)
//   CNT_W    width of the Repeat input
//   GAP      idle cycles between consecutive frames (0 = back-to-back)
//   IDLE_BIT level driven on Dout when no pattern bit is being sent
//
// Ports
//   CLK        in   rising-edge clock
//   nRST       in   synchronous active-low reset
//   Start      in   job request, accepted on an edge where Start=1 and Ready=1
//   Pattern    in   pattern sampled at acceptance
//   Repeat     in   frame count sampled at acceptance
//   Ready      out  high only while idle and able to accept a job
//   Dout       out  registered serial data
//   Dout_vld   out  registered, high while Dout carries a pattern bit
//   Frame_end  out  one-cycle pulse coincident with the LSB of each frame
//   Done       out  one-cycle pulse the cycle after the last frame's LSB

module serial_pattern_gen #(
    parameter int   PAT_W    = 8,
    parameter int   CNT_W    = 4,
    parameter int   GAP      = 2,
    parameter logic IDLE_BIT = 1'b0
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             Start,
    input  logic [PAT_W-1:0] Pattern,
    input  logic [CNT_W-1:0] Repeat,
    output logic             Ready,
    output logic             Dout,
    output logic             Dout_vld,
    output logic             Frame_end,
    output logic             Done
);

    localparam int BIT_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(PAT_W - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = (GAP > 0) ? GAP_W'(GAP - 1) : '0;
    localparam logic [CNT_W-1:0] ONE_REP  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAPW,
        DONE
    } state_t;

    state_t           state, state_nxt;
    logic [PAT_W-1:0] shreg, shreg_nxt;
    logic [PAT_W-1:0] held, held_nxt;
    logic [BIT_W-1:0] bitcnt, bitcnt_nxt;
    logic [CNT_W-1:0] reps, reps_nxt;
    logic [GAP_W-1:0] gapcnt, gapcnt_nxt;
    logic             dout_nxt;
    logic             vld_nxt;
    logic             fend_nxt;
    logic             done_nxt;

    // The Done pulse is registered and appears while the state register is
    // already back in IDLE, so Ready is held low for that cycle as well; a job
    // can only be accepted once the pulse is over.
    assign Ready = (state == IDLE) && !Done;

    // Next-state and next-output logic. Outputs are registered, so a value
    // computed here appears on the pins one cycle after the state that
    // produced it.
    always_comb begin
        state_nxt  = state;
        shreg_nxt  = shreg;
        held_nxt   = held;
        bitcnt_nxt = bitcnt;
        reps_nxt   = reps;
        gapcnt_nxt = gapcnt;
        dout_nxt   = IDLE_BIT;
        vld_nxt    = 1'b0;
        fend_nxt   = 1'b0;
        done_nxt   = 1'b0;

        case (state)
            IDLE: begin
                if (Start && Ready) begin
                    shreg_nxt  = Pattern;
                    held_nxt   = Pattern;
                    bitcnt_nxt = LAST_BIT;
                    reps_nxt   = (Repeat == '0) ? ONE_REP : Repeat;
                    state_nxt  = SEND;
                end
            end

            SEND: begin
                dout_nxt  = shreg[PAT_W-1];
                vld_nxt   = 1'b1;
                shreg_nxt = {shreg[PAT_W-2:0], 1'b0};
                if (bitcnt == '0) begin
                    fend_nxt = 1'b1;
                    if (reps > ONE_REP) begin
                        // The shift register has been consumed, so the next
                        // frame restarts from the copy taken at acceptance.
                        reps_nxt   = reps - ONE_REP;
                        shreg_nxt  = held;
                        bitcnt_nxt = LAST_BIT;
                        if (GAP > 0) begin
                            gapcnt_nxt = GAP_LOAD;
                            state_nxt  = GAPW;
                        end
                    end else begin
                        state_nxt = DONE;
                    end
                end else begin
                    bitcnt_nxt = bitcnt - BIT_W'(1);
                end
            end

            GAPW: begin
                if (gapcnt == '0) begin
                    state_nxt = SEND;
                end else begin
                    gapcnt_nxt = gapcnt - GAP_W'(1);
                end
            end

            DONE: begin
                done_nxt  = 1'b1;
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any running job at once.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state     <= IDLE;
            shreg     <= '0;
            held      <= '0;
            bitcnt    <= '0;
            reps      <= '0;
            gapcnt    <= '0;
            Dout      <= IDLE_BIT;
            Dout_vld  <= 1'b0;
            Frame_end <= 1'b0;
            Done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            shreg     <= shreg_nxt;
            held      <= held_nxt;
            bitcnt    <= bitcnt_nxt;
            reps      <= reps_nxt;
            gapcnt    <= gapcnt_nxt;
            Dout      <= dout_nxt;
            Dout_vld  <= vld_nxt;
            Frame_end <= fend_nxt;
            Done      <= done_nxt;
        end
    end

endmodule

// File: tb/tb_serial_pattern_gen.sv
// tb_serial_pattern_gen
//   Drives two transmitters (GAP=2 and GAP=0) with the same stimulus and checks
//   every output on every cycle against a job-level model: each accepted job is
//   described by its acceptance cycle, pattern and frame count, and the expected
//   outputs of any cycle are derived arithmetically from that description.
//   Directed jobs additionally pin captured bit streams and pulse timing to
//   hand-computed constants.

module tb_serial_pattern_gen;

    logic       CLK = 1'b0;
    logic       nRST = 1'b0;
    logic       Start = 1'b0;
    logic [7:0] Pattern = '0;
    logic [3:0] Repeat = '0;

    logic rdy [2];
    logic dout[2];
    logic vld [2];
    logic fend[2];
    logic done[2];

    int nChecks = 0;
    int nFails  = 0;
    int cyc     = 0;
    bit checkEn = 1'b0;

    // Job model per instance
    bit         jv[2];
    int         jt[2];
    logic [7:0] jp[2];
    int         jn[2];

    // Captured DUT behaviour for directed literal checks
    logic [63:0] cap[2];
    int          capN[2];
    int          fendCnt[2];
    int          fendFirst[2];
    int          doneCyc[2];

    serial_pattern_gen #(.PAT_W(8), .CNT_W(4), .GAP(2), .IDLE_BIT(1'b0)) dutGap2 (
        .CLK(CLK), .nRST(nRST), .Start(Start), .Pattern(Pattern), .Repeat(Repeat),
        .Ready(rdy[0]), .Dout(dout[0]), .Dout_vld(vld[0]), .Frame_end(fend[0]), .Done(done[0])
    );

    serial_pattern_gen #(.PAT_W(8), .CNT_W(4), .GAP(0), .IDLE_BIT(1'b0)) dutGap0 (
        .CLK(CLK), .nRST(nRST), .Start(Start), .Pattern(Pattern), .Repeat(Repeat),
        .Ready(rdy[1]), .Dout(dout[1]), .Dout_vld(vld[1]), .Frame_end(fend[1]), .Done(done[1])
    );

    always #5 CLK = ~CLK;

    function automatic int gapOf(input int i);
        return (i == 0) ? 2 : 0;
    endfunction

    // Expected outputs in cycle c (the period following posedge number c).
    // Frame k of a job accepted at edge t occupies cycles t+1+k*(8+G) .. +7,
    // the last LSB lands at L = t + 8n + G(n-1), Done follows at L+1 and the
    // transmitter is not ready from t through L+1.
    function automatic void modelOut(input int i, input int c,
                                     output logic ed, output logic ev, output logic ef,
                                     output logic edn, output logic er);
        int g, per, lastLsb, off, k, j;
        ed = 1'b0; ev = 1'b0; ef = 1'b0; edn = 1'b0; er = 1'b1;
        if (jv[i]) begin
            g       = gapOf(i);
            per     = 8 + g;
            lastLsb = jt[i] + jn[i] * 8 + (jn[i] - 1) * g;
            edn     = (c == lastLsb + 1);
            er      = !(c >= jt[i] && c <= lastLsb + 1);
            off     = c - jt[i] - 1;
            if (off >= 0) begin
                k = off / per;
                j = off % per;
                if (k < jn[i] && j < 8) begin
                    ev = 1'b1;
                    ed = jp[i][7 - j];
                    ef = (j == 7);
                end
            end
        end
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic [7:0] p, input logic [3:0] r, input logic rstN);
        @(negedge CLK);
        Start   = s;
        Pattern = p;
        Repeat  = r;
        nRST    = rstN;
    endtask

    task automatic clearCapture();
        for (int i = 0; i < 2; i++) begin
            cap[i]       = '0;
            capN[i]      = 0;
            fendCnt[i]   = 0;
            fendFirst[i] = -1;
            doneCyc[i]   = -1;
        end
    endtask

    // One Start pulse, then idle inputs for the given number of cycles.
    task automatic runJob(input logic [7:0] p, input logic [3:0] r, input int cycles, output int acc);
        applyStimulus(1'b1, p, r, 1'b1);
        acc = cyc + 1;
        clearCapture();
        repeat (cycles) applyStimulus(1'b0, 8'h00, 4'd0, 1'b1);
    endtask

    // Model update at each edge, using the inputs the DUTs sample there.
    always @(posedge CLK) begin
        logic ed, ev, ef, edn, er;
        cyc++;
        for (int i = 0; i < 2; i++) begin
            modelOut(i, cyc - 1, ed, ev, ef, edn, er);
            if (!nRST) begin
                jv[i] = 1'b0;
            end else if (er && Start) begin
                jv[i] = 1'b1;
                jt[i] = cyc;
                jp[i] = Pattern;
                jn[i] = (Repeat == 4'd0) ? 1 : int'(Repeat);
            end
        end
        if (!nRST) checkEn = 1'b1;
    end

    // Per-cycle comparison against the model, plus capture for literal checks.
    always @(negedge CLK) begin
        logic ed, ev, ef, edn, er;
        if (checkEn) begin
            for (int i = 0; i < 2; i++) begin
                modelOut(i, cyc, ed, ev, ef, edn, er);
                checkOutput($sformatf("gap%0d Dout", gapOf(i)),      32'(dout[i]), 32'(ed));
                checkOutput($sformatf("gap%0d Dout_vld", gapOf(i)),  32'(vld[i]),  32'(ev));
                checkOutput($sformatf("gap%0d Frame_end", gapOf(i)), 32'(fend[i]), 32'(ef));
                checkOutput($sformatf("gap%0d Done", gapOf(i)),      32'(done[i]), 32'(edn));
                checkOutput($sformatf("gap%0d Ready", gapOf(i)),     32'(rdy[i]),  32'(er));
                if (vld[i] === 1'b1) begin
                    cap[i] = {cap[i][62:0], dout[i]};
                    capN[i]++;
                end
                if (fend[i] === 1'b1) begin
                    fendCnt[i]++;
                    if (fendFirst[i] < 0) fendFirst[i] = cyc;
                end
                if (done[i] === 1'b1) doneCyc[i] = cyc;
            end
        end
    end

    initial begin
        int acc;
        clearCapture();
        for (int i = 0; i < 2; i++) jv[i] = 1'b0;

        $display("[TB] reset");
        applyStimulus(1'b0, 8'h00, 4'd0, 1'b0);
        applyStimulus(1'b0, 8'h00, 4'd0, 1'b0);
        applyStimulus(1'b0, 8'h00, 4'd0, 1'b1);
        checkOutput("reset Ready", 32'(rdy[0]), 32'd1);
        checkOutput("reset Dout_vld", 32'(vld[0]), 32'd0);
        checkOutput("reset Dout", 32'(dout[0]), 32'd0);

        $display("[TB] single frame 0xB6");
        runJob(8'hB6, 4'd1, 12, acc);
        checkOutput("t1 stream", 32'(cap[0][7:0]), 32'hB6);
        checkOutput("t1 bit count", capN[0], 8);
        checkOutput("t1 Frame_end offset", fendFirst[0] - acc, 8);
        checkOutput("t1 Done offset", doneCyc[0] - acc, 9);

        $display("[TB] three frames 0xA5 with gap");
        runJob(8'hA5, 4'd3, 33, acc);
        checkOutput("t2 stream", cap[0][31:0], 32'h00A5A5A5);
        checkOutput("t2 frame ends", fendCnt[0], 3);
        checkOutput("t2 Done offset", doneCyc[0] - acc, 29);

        $display("[TB] repeat zero runs once");
        runJob(8'hFF, 4'd0, 12, acc);
        checkOutput("t3 stream", 32'(cap[0][7:0]), 32'hFF);
        checkOutput("t3 bit count", capN[0], 8);
        checkOutput("t3 Done offset", doneCyc[0] - acc, 9);

        $display("[TB] Start held high with changing Pattern");
        repeat (80) applyStimulus(1'b1, 8'($urandom), 4'($urandom_range(1, 2)), 1'b1);
        repeat (30) applyStimulus(1'b0, 8'h00, 4'd0, 1'b1);

        $display("[TB] reset during frame 2");
        applyStimulus(1'b1, 8'h3C, 4'd3, 1'b1);
        acc = cyc + 1;
        clearCapture();
        repeat (14) applyStimulus(1'b0, 8'h00, 4'd0, 1'b1);
        checkOutput("t5 mid-frame valid", 32'(vld[0]), 32'd1);
        applyStimulus(1'b0, 8'h00, 4'd0, 1'b0);
        applyStimulus(1'b0, 8'h00, 4'd0, 1'b1);
        checkOutput("t5 Ready after reset", 32'(rdy[0]), 32'd1);
        checkOutput("t5 Dout_vld after reset", 32'(vld[0]), 32'd0);
        checkOutput("t5 Dout after reset", 32'(dout[0]), 32'd0);
        repeat (20) applyStimulus(1'b0, 8'h00, 4'd0, 1'b1);
        checkOutput("t5 frame ends", fendCnt[0], 1);
        checkOutput("t5 no Done", doneCyc[0], -1);
        runJob(8'h5A, 4'd1, 12, acc);
        checkOutput("t5 fresh stream", 32'(cap[0][7:0]), 32'h5A);
        checkOutput("t5 fresh Done offset", doneCyc[0] - acc, 9);

        $display("[TB] back-to-back frames 0x81");
        runJob(8'h81, 4'd2, 24, acc);
        checkOutput("t6 stream", 32'(cap[1][15:0]), 32'h8181);
        checkOutput("t6 bit count", capN[1], 16);
        checkOutput("t6 Done offset", doneCyc[1] - acc, 17);

        $display("[TB] random traffic");
        for (int n = 0; n < 600; n++) begin
            applyStimulus($urandom_range(0, 3) == 0, 8'($urandom), 4'($urandom_range(0, 3)),
                          $urandom_range(0, 99) != 0);
        end
        repeat (40) applyStimulus(1'b0, 8'h00, 4'd0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
